// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I OP/OP-IMM/LUI/AUIPC decode and operand select
// into a 2-entry issue queue with valid/ready on both sides.
module alu_issue_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 10
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_pc,
  input  logic [31:0]         in_inst,
  output logic [4:0]          rf_raddr1,
  output logic [4:0]          rf_raddr2,
  input  logic [XLEN-1:0]     rf_rdata1,
  input  logic [XLEN-1:0]     rf_rdata2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [XLEN-1:0]     out_alu_src1,
  output logic [XLEN-1:0]     out_alu_src2,
  output logic [4:0]          out_rd,
  output logic                out_rf_we,
  output logic                out_illegal
);

  // One-hot bit positions of alu_op, add in the MSB.
  localparam int OP_ADD  = 9;
  localparam int OP_SUB  = 8;
  localparam int OP_SLL  = 7;
  localparam int OP_SLT  = 6;
  localparam int OP_SLTU = 5;
  localparam int OP_XOR  = 4;
  localparam int OP_SRL  = 3;
  localparam int OP_SRA  = 2;
  localparam int OP_OR   = 1;
  localparam int OP_AND  = 0;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [ALU_OP_W-1:0] alu_op;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [4:0]          rd;
    logic                rf_we;
    logic                illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  occ_t   state_q, state_d;
  entry_t head_q, tail_q;
  entry_t dec;
  logic   accept, pop;
  logic   load_head, load_tail, shift;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_u, shamt;
  logic [ALU_OP_W-1:0] op_sel;
  logic [XLEN-1:0] sel1, sel2;
  logic            legal;

  function automatic logic [ALU_OP_W-1:0] onehot(input int idx);
    logic [ALU_OP_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  assign opcode    = in_inst[6:0];
  assign f3        = in_inst[14:12];
  assign f7        = in_inst[31:25];
  assign rf_raddr1 = in_inst[19:15];
  assign rf_raddr2 = in_inst[24:20];
  assign imm_i     = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_u     = {in_inst[31:12], 12'b0};
  assign shamt     = {{(XLEN-5){1'b0}}, in_inst[24:20]};

  // Register and immediate forms share one f3 map; only OP has sub.
  always_comb begin
    op_sel = '0;
    sel1   = '0;
    sel2   = '0;
    legal  = 1'b0;
    unique case (opcode)
      OPC_OP, OPC_OPIMM: begin
        sel1  = rf_rdata1;
        sel2  = (opcode == OPC_OP) ? rf_rdata2 : imm_i;
        legal = 1'b1;
        unique case (f3)
          3'b000: begin
            if (opcode == OPC_OPIMM || f7 == F7_BASE) op_sel = onehot(OP_ADD);
            else if (f7 == F7_ALT)                    op_sel = onehot(OP_SUB);
            else                                      legal  = 1'b0;
          end
          3'b001: begin
            op_sel = onehot(OP_SLL);
            legal  = (f7 == F7_BASE);
          end
          3'b101: begin
            if (f7 == F7_BASE)     op_sel = onehot(OP_SRL);
            else if (f7 == F7_ALT) op_sel = onehot(OP_SRA);
            else                   legal  = 1'b0;
          end
          3'b010: begin
            op_sel = onehot(OP_SLT);
            legal  = (opcode == OPC_OPIMM) || (f7 == F7_BASE);
          end
          3'b011: begin
            op_sel = onehot(OP_SLTU);
            legal  = (opcode == OPC_OPIMM) || (f7 == F7_BASE);
          end
          3'b100: begin
            op_sel = onehot(OP_XOR);
            legal  = (opcode == OPC_OPIMM) || (f7 == F7_BASE);
          end
          3'b110: begin
            op_sel = onehot(OP_OR);
            legal  = (opcode == OPC_OPIMM) || (f7 == F7_BASE);
          end
          default: begin
            op_sel = onehot(OP_AND);
            legal  = (opcode == OPC_OPIMM) || (f7 == F7_BASE);
          end
        endcase
        if (opcode == OPC_OPIMM && (f3 == 3'b001 || f3 == 3'b101)) sel2 = shamt;
      end
      OPC_LUI: begin
        op_sel = onehot(OP_ADD);
        sel2   = imm_u;
        legal  = 1'b1;
      end
      OPC_AUIPC: begin
        op_sel = onehot(OP_ADD);
        sel1   = in_pc;
        sel2   = imm_u;
        legal  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries carry no op and no operands so execute never sees stale data.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.rd      = in_inst[11:7];
    dec.illegal = ~legal;
    dec.rf_we   = legal & (in_inst[11:7] != 5'd0);
    if (legal) begin
      dec.alu_op = op_sel;
      dec.src1   = sel1;
      dec.src2   = sel2;
    end
  end

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d   = ONE;
            load_head = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_head = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            load_tail = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            state_d = ONE;
            shift   = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_head)  head_q <= dec;
      else if (shift) head_q <= tail_q;
      if (load_tail)  tail_q <= dec;
    end
  end

  assign out_pc       = head_q.pc;
  assign out_alu_op   = head_q.alu_op;
  assign out_alu_src1 = head_q.src1;
  assign out_alu_src2 = head_q.src2;
  assign out_rd       = head_q.rd;
  assign out_rf_we    = head_q.rf_we;
  assign out_illegal  = head_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed checks of alu_issue_stage decode, queueing,
// flush and reset.
module tb_alu_issue_stage;

  logic        clk;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [9:0]  out_alu_op;
  logic [31:0] out_alu_src1;
  logic [31:0] out_alu_src2;
  logic [4:0]  out_rd;
  logic        out_rf_we;
  logic        out_illegal;

  int checks = 0;
  int errors = 0;

  alu_issue_stage dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_inst      (in_inst),
    .rf_raddr1    (rf_raddr1),
    .rf_raddr2    (rf_raddr2),
    .rf_rdata1    (rf_rdata1),
    .rf_rdata2    (rf_rdata2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_alu_op   (out_alu_op),
    .out_alu_src1 (out_alu_src1),
    .out_alu_src2 (out_alu_src2),
    .out_rd       (out_rd),
    .out_rf_we    (out_rf_we),
    .out_illegal  (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_inst   = inst;
    rf_rdata1 = r1;
    rf_rdata2 = r2;
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_inst   = '0;
    rf_rdata1 = '0;
    rf_rdata2 = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_alu_op", {22'b0, out_alu_op}, 32'd0);
    resetn    = 1'b1;
    out_ready = 1'b1;
    tick();

    // ADDI x1,x0,5
    drive(32'h0000_0100, 32'h0050_0093, 32'h0, 32'h0);
    #1;
    chk("addi_raddr1", {27'b0, rf_raddr1}, 32'd0);
    chk("addi_raddr2", {27'b0, rf_raddr2}, 32'd5);
    tick();
    chk("addi_valid", {31'b0, out_valid}, 32'd1);
    chk("addi_op", {22'b0, out_alu_op}, 32'h200);
    chk("addi_src1", out_alu_src1, 32'd0);
    chk("addi_src2", out_alu_src2, 32'd5);
    chk("addi_rd", {27'b0, out_rd}, 32'd1);
    chk("addi_we", {31'b0, out_rf_we}, 32'd1);
    chk("addi_pc", out_pc, 32'h0000_0100);

    // SUB x3,x1,x2
    drive(32'h0000_0104, 32'h4020_81B3, 32'd7, 32'd2);
    #1;
    chk("sub_raddr1", {27'b0, rf_raddr1}, 32'd1);
    chk("sub_raddr2", {27'b0, rf_raddr2}, 32'd2);
    tick();
    chk("sub_op", {22'b0, out_alu_op}, 32'h100);
    chk("sub_src1", out_alu_src1, 32'd7);
    chk("sub_src2", out_alu_src2, 32'd2);
    chk("sub_rd", {27'b0, out_rd}, 32'd3);
    chk("sub_illegal", {31'b0, out_illegal}, 32'd0);

    // SRAI x5,x6,3
    drive(32'h0000_0108, 32'h4033_5293, 32'hF000_0000, 32'h1234_5678);
    tick();
    chk("srai_op", {22'b0, out_alu_op}, 32'h004);
    chk("srai_src1", out_alu_src1, 32'hF000_0000);
    chk("srai_src2", out_alu_src2, 32'd3);
    chk("srai_rd", {27'b0, out_rd}, 32'd5);

    // SRAI with funct7=0x10 is not a valid shift
    drive(32'h0000_010C, 32'h2033_5293, 32'hF000_0000, 32'h0);
    tick();
    chk("srai_bad_illegal", {31'b0, out_illegal}, 32'd1);
    chk("srai_bad_we", {31'b0, out_rf_we}, 32'd0);
    chk("srai_bad_op", {22'b0, out_alu_op}, 32'd0);
    chk("srai_bad_rd", {27'b0, out_rd}, 32'd5);

    // LUI x7,0x12345
    drive(32'h0000_0110, 32'h1234_53B7, 32'hAAAA_AAAA, 32'h0);
    tick();
    chk("lui_op", {22'b0, out_alu_op}, 32'h200);
    chk("lui_src1", out_alu_src1, 32'd0);
    chk("lui_src2", out_alu_src2, 32'h1234_5000);
    chk("lui_rd", {27'b0, out_rd}, 32'd7);

    // AUIPC x7,0x12345
    drive(32'h8000_0010, 32'h1234_5397, 32'hAAAA_AAAA, 32'h0);
    tick();
    chk("auipc_op", {22'b0, out_alu_op}, 32'h200);
    chk("auipc_src1", out_alu_src1, 32'h8000_0010);
    chk("auipc_src2", out_alu_src2, 32'h1234_5000);

    // ADDI x1,x0,-1 sign-extends the immediate
    drive(32'h0000_0118, 32'hFFF0_0093, 32'h0, 32'h0);
    tick();
    chk("addi_neg_src2", out_alu_src2, 32'hFFFF_FFFF);

    // SLTU x4,x1,x2
    drive(32'h0000_011C, 32'h0020_B233, 32'd9, 32'd4);
    tick();
    chk("sltu_op", {22'b0, out_alu_op}, 32'h020);
    chk("sltu_src2", out_alu_src2, 32'd4);
    chk("sltu_rd", {27'b0, out_rd}, 32'd4);

    // ECALL: unsupported opcode, operands must be zeroed
    drive(32'h0000_0120, 32'h0000_0073, 32'h0000_0055, 32'h0000_0066);
    tick();
    chk("ecall_illegal", {31'b0, out_illegal}, 32'd1);
    chk("ecall_op", {22'b0, out_alu_op}, 32'd0);
    chk("ecall_src1", out_alu_src1, 32'd0);
    chk("ecall_src2", out_alu_src2, 32'd0);
    chk("ecall_we", {31'b0, out_rf_we}, 32'd0);

    // ADDI x0,x0,5: legal but no writeback
    drive(32'h0000_0124, 32'h0050_0013, 32'h0, 32'h0);
    tick();
    chk("addi_x0_we", {31'b0, out_rf_we}, 32'd0);
    chk("addi_x0_illegal", {31'b0, out_illegal}, 32'd0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'b0, out_valid}, 32'd0);

    // Back-to-back A,B,C with consumer stalled
    out_ready = 1'b0;
    drive(32'h0000_0010, 32'h0050_0093, 32'h0, 32'h0);
    tick();
    chk("q_a_in_ready", {31'b0, in_ready}, 32'd1);
    chk("q_a_rd", {27'b0, out_rd}, 32'd1);
    drive(32'h0000_0014, 32'h0050_0113, 32'h0, 32'h0);
    tick();
    chk("q_two_in_ready", {31'b0, in_ready}, 32'd0);
    chk("q_two_head", out_pc, 32'h0000_0010);
    drive(32'h0000_0018, 32'h0050_0193, 32'h0, 32'h0);
    tick();
    chk("q_hold_in_ready", {31'b0, in_ready}, 32'd0);
    chk("q_hold_head", out_pc, 32'h0000_0010);
    chk("q_hold_rd", {27'b0, out_rd}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("q_b_pc", out_pc, 32'h0000_0014);
    chk("q_b_rd", {27'b0, out_rd}, 32'd2);
    chk("q_b_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("q_c_pc", out_pc, 32'h0000_0018);
    chk("q_c_rd", {27'b0, out_rd}, 32'd3);
    chk("q_c_valid", {31'b0, out_valid}, 32'd1);
    tick();
    chk("q_empty_valid", {31'b0, out_valid}, 32'd0);

    // Flush while full with an incoming instruction
    out_ready = 1'b0;
    drive(32'h0000_0020, 32'h0050_0093, 32'h0, 32'h0);
    tick();
    drive(32'h0000_0024, 32'h0050_0113, 32'h0, 32'h0);
    tick();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    drive(32'h0000_0028, 32'h0050_0193, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("fl_dropped", {31'b0, out_valid}, 32'd0);

    // Flush beats an accept into an empty queue
    drive(32'h0000_002C, 32'h0050_0093, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_empty_accept", {31'b0, out_valid}, 32'd0);

    // Reset mid-stream with the queue full
    drive(32'h0000_0040, 32'h4020_81B3, 32'd7, 32'd2);
    tick();
    drive(32'h0000_0044, 32'h1234_53B7, 32'h0, 32'h0);
    tick();
    chk("mr_full", {31'b0, in_ready}, 32'd0);
    drive(32'h0000_0048, 32'h0050_0093, 32'h0, 32'h0);
    resetn = 1'b0;
    tick();
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_pc", out_pc, 32'd0);
    chk("mr_op", {22'b0, out_alu_op}, 32'd0);
    chk("mr_src1", out_alu_src1, 32'd0);
    chk("mr_src2", out_alu_src2, 32'd0);
    chk("mr_rd", {27'b0, out_rd}, 32'd0);
    chk("mr_we", {31'b0, out_rf_we}, 32'd0);
    chk("mr_illegal", {31'b0, out_illegal}, 32'd0);
    resetn   = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("mr_in_ready", {31'b0, in_ready}, 32'd1);
    chk("mr_after_valid", {31'b0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
